// File: rtl/cpu6502_int_ctl_pkg.sv
// rtl/cpu6502_int_ctl_pkg.sv - shared encodings and vector defaults for the interrupt sequencer
package cpu6502_int_ctl_pkg;

  typedef enum logic [1:0] {
    ICTL_RST  = 2'd0,
    ICTL_IDLE = 2'd1,
    ICTL_INT  = 2'd2,
    ICTL_VHI  = 2'd3
  } ictl_state_e;

  localparam logic [7:0] VEC_NMI_DEF = 8'hFA;
  localparam logic [7:0] VEC_RST_DEF = 8'hFC;
  localparam logic [7:0] VEC_IRQ_DEF = 8'hFE;

  // Position of B in reg_p; the pushed copy comes from b_flag.
  localparam int PF_B = 4;

  function automatic logic [7:0] pick_vector(input logic nmi_sel,
                                             input logic [7:0] vec_nmi,
                                             input logic [7:0] vec_irq);
    return nmi_sel ? vec_nmi : vec_irq;
  endfunction

endpackage

// File: rtl/cpu6502_sync.sv
// rtl/cpu6502_sync.sv - N-stage pin synchroniser, pass-through when STAGES is 0
module cpu6502_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ reset;
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] sr;
      always_ff @(posedge clk) begin
        if (reset) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/cpu6502_int_ctl.sv
// rtl/cpu6502_int_ctl.sv - NMI/IRQ/reset sequencer: forces BRK, holds PC, supplies vector and B bit
module cpu6502_int_ctl
  import cpu6502_int_ctl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] VEC_NMI     = VEC_NMI_DEF,
  parameter logic [7:0] VEC_RST     = VEC_RST_DEF,
  parameter logic [7:0] VEC_IRQ     = VEC_IRQ_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nmi,
  input  logic       irq,
  input  logic       ready,
  input  logic       last_cyc,
  input  logic       i_flag,
  input  logic       vec_fetch,
  output logic       force_brk,
  output logic       pc_hold,
  output logic       wr_inhibit,
  output logic       b_flag,
  output logic [7:0] vector_lo,
  output logic       set_i,
  output logic       nmi_pending,
  output logic       irq_pending
);

  logic        nmi_s, irq_s, nmi_prev, nmi_latch, nmi_edge, vf_en, nmi_sel;
  logic        vhi_wr, vhi_b;
  logic [7:0]  vec_hold;
  ictl_state_e state;

  cpu6502_sync #(.STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk(clk), .reset(reset), .d(nmi), .q(nmi_s)
  );

  cpu6502_sync #(.STAGES(SYNC_STAGES)) u_sync_irq (
    .clk(clk), .reset(reset), .d(irq), .q(irq_s)
  );

  assign vf_en       = vec_fetch & ready;
  assign nmi_edge    = nmi_s & ~nmi_prev;
  assign irq_pending = irq_s & ~i_flag;
  assign nmi_pending = nmi_latch;
  assign set_i       = vf_en;
  // The NMI vector is only ever live in IDLE (software BRK) and INT.
  assign nmi_sel     = nmi_latch & ((state == ICTL_IDLE) | (state == ICTL_INT));

  always_ff @(posedge clk) begin
    nmi_prev <= nmi_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_latch <= 1'b0;
    end else if (nmi_edge) begin
      nmi_latch <= 1'b1;
    end else if (vf_en && nmi_sel) begin
      nmi_latch <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ICTL_RST;
      vec_hold <= VEC_RST;
      vhi_wr   <= 1'b1;
      vhi_b    <= 1'b0;
    end else if (ready) begin
      if (vec_fetch) begin
        vec_hold <= vector_lo;
        vhi_wr   <= wr_inhibit;
        vhi_b    <= b_flag;
      end
      case (state)
        ICTL_RST:  if (vec_fetch) state <= ICTL_VHI;
        ICTL_IDLE: if (last_cyc && (nmi_latch || irq_pending)) state <= ICTL_INT;
        ICTL_INT:  if (vec_fetch) state <= ICTL_VHI;
        default:   state <= ICTL_IDLE;
      endcase
    end
  end

  always_comb begin
    force_brk  = 1'b0;
    pc_hold    = 1'b0;
    wr_inhibit = 1'b0;
    b_flag     = 1'b1;
    vector_lo  = pick_vector(nmi_latch, VEC_NMI, VEC_IRQ);
    case (state)
      ICTL_RST: begin
        force_brk  = 1'b1;
        pc_hold    = 1'b1;
        wr_inhibit = 1'b1;
        b_flag     = 1'b0;
        vector_lo  = VEC_RST;
      end
      ICTL_INT: begin
        force_brk = 1'b1;
        pc_hold   = 1'b1;
        b_flag    = 1'b0;
      end
      ICTL_VHI: begin
        pc_hold    = 1'b1;
        wr_inhibit = vhi_wr;
        b_flag     = vhi_b;
        vector_lo  = vec_hold;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu6502_int_ctl.sv
// tb/tb_cpu6502_int_ctl.sv - scoreboard bench for the interrupt/reset sequencer
module tb_cpu6502_int_ctl;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset, nmi, irq, ready, last_cyc, i_flag, vec_fetch;
  logic       force_brk, pc_hold, wr_inhibit, b_flag, set_i, nmi_pending, irq_pending;
  logic [7:0] vector_lo;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_vec[$];
  logic [7:0] exp;

  always #5 clk = ~clk;

  cpu6502_int_ctl #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .nmi(nmi), .irq(irq), .ready(ready),
    .last_cyc(last_cyc), .i_flag(i_flag), .vec_fetch(vec_fetch),
    .force_brk(force_brk), .pc_hold(pc_hold), .wr_inhibit(wr_inhibit),
    .b_flag(b_flag), .vector_lo(vector_lo), .set_i(set_i),
    .nmi_pending(nmi_pending), .irq_pending(irq_pending)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1; nmi = 0; irq = 0; ready = 1; last_cyc = 0; i_flag = 1; vec_fetch = 0;
    tick(3);
    checks++; if (force_brk !== 1'b1) begin errors++; $display("FAIL rst_force_brk got %b exp 1", force_brk); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_pc_hold got %b exp 1", pc_hold); end
    checks++; if (b_flag !== 1'b0) begin errors++; $display("FAIL rst_b_flag got %b exp 0", b_flag); end
    checks++; if (set_i !== 1'b0) begin errors++; $display("FAIL rst_set_i got %b exp 0", set_i); end
    checks++; if (nmi_pending !== 1'b0) begin errors++; $display("FAIL rst_nmi_pending got %b exp 0", nmi_pending); end
    reset = 0;
    exp_vec.push_back(8'hFC);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++; if (vector_lo !== 8'hFC || wr_inhibit !== 1'b1) begin
        errors++; $display("FAIL rst_seq cyc %0d got vec %h wr %b exp vec fc wr 1", c, vector_lo, wr_inhibit);
      end
    end
    vec_fetch = 1; #1;
    checks++; if (set_i !== 1'b1) begin errors++; $display("FAIL rst_set_i_vf got %b exp 1", set_i); end
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp) begin errors++; $display("FAIL rst_vec got %h exp %h", vector_lo, exp); end
    tick(1); vec_fetch = 0; #1;
    checks++; if (vector_lo !== 8'hFC || wr_inhibit !== 1'b1) begin
      errors++; $display("FAIL rst_vhi got vec %h wr %b exp vec fc wr 1", vector_lo, wr_inhibit);
    end
    tick(1);
    checks++; if (wr_inhibit !== 1'b0 || force_brk !== 1'b0 || b_flag !== 1'b1) begin
      errors++; $display("FAIL rst_idle got wr %b fb %b b %b exp wr 0 fb 0 b 1", wr_inhibit, force_brk, b_flag);
    end
  endtask

  task automatic test_irq_masked;
    irq = 1; i_flag = 1;
    for (int c = 0; c < 50; c++) begin
      last_cyc = (c % 5 == 4);
      tick(1);
      checks++; if (force_brk !== 1'b0 || irq_pending !== 1'b0) begin
        errors++; $display("FAIL irq_masked cyc %0d got fb %b pend %b exp 0 0", c, force_brk, irq_pending);
      end
    end
    last_cyc = 0;
  endtask

  task automatic test_irq_take;
    i_flag = 0;
    exp_vec.push_back(8'hFE);
    tick(SS);
    last_cyc = 1; tick(1); last_cyc = 0;
    irq = 0; #1;
    checks++; if (force_brk !== 1'b1 || b_flag !== 1'b0 || pc_hold !== 1'b1) begin
      errors++; $display("FAIL irq_take got fb %b b %b ph %b exp 1 0 1", force_brk, b_flag, pc_hold);
    end
    tick(3);
    vec_fetch = 1; #1;
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp) begin errors++; $display("FAIL irq_vec got %h exp %h", vector_lo, exp); end
    i_flag = 1;
    tick(1); vec_fetch = 0; #1;
    checks++; if (vector_lo !== 8'hFE || b_flag !== 1'b0) begin
      errors++; $display("FAIL irq_vhi got vec %h b %b exp fe 0", vector_lo, b_flag);
    end
    tick(1);
    checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL irq_done got %b exp 0", force_brk); end
    i_flag = 0;
    tick(SS + 1);
  endtask

  task automatic test_nmi;
    nmi = 1;
    exp_vec.push_back(8'hFA);
    for (int k = 1; k <= SS + 1; k++) begin
      tick(1);
      checks++; if (nmi_pending !== (k == SS + 1)) begin
        errors++; $display("FAIL nmi_sync k %0d got %b exp %b", k, nmi_pending, (k == SS + 1));
      end
    end
    last_cyc = 1; tick(1); last_cyc = 0; #1;
    checks++; if (force_brk !== 1'b1) begin errors++; $display("FAIL nmi_take got %b exp 1", force_brk); end
    tick(2);
    vec_fetch = 1; #1;
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp) begin errors++; $display("FAIL nmi_vec got %h exp %h", vector_lo, exp); end
    tick(1); vec_fetch = 0; #1;
    checks++; if (nmi_pending !== 1'b0 || vector_lo !== 8'hFA) begin
      errors++; $display("FAIL nmi_clear got pend %b vec %h exp 0 fa", nmi_pending, vector_lo);
    end
    tick(1);
    for (int c = 0; c < 20; c++) begin
      last_cyc = (c % 4 == 3);
      tick(1);
      checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL nmi_retake cyc %0d got %b exp 0", c, force_brk); end
    end
    last_cyc = 0; nmi = 0;
    tick(SS + 1);
  endtask

  task automatic test_hijack;
    irq = 1; i_flag = 0;
    exp_vec.push_back(8'hFA);
    tick(SS);
    last_cyc = 1; tick(1); last_cyc = 0; #1;
    checks++; if (force_brk !== 1'b1 || vector_lo !== 8'hFE) begin
      errors++; $display("FAIL hij_take got fb %b vec %h exp 1 fe", force_brk, vector_lo);
    end
    nmi = 1;
    tick(SS + 1);
    checks++; if (vector_lo !== 8'hFA) begin errors++; $display("FAIL hij_live got %h exp fa", vector_lo); end
    tick(1);
    vec_fetch = 1; #1;
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp) begin errors++; $display("FAIL hij_vec got %h exp %h", vector_lo, exp); end
    i_flag = 1;
    tick(1); vec_fetch = 0; irq = 0; #1;
    checks++; if (nmi_pending !== 1'b0) begin errors++; $display("FAIL hij_clear got %b exp 0", nmi_pending); end
    tick(1);
    for (int c = 0; c < 20; c++) begin
      last_cyc = (c % 4 == 3);
      tick(1);
      checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL hij_retake cyc %0d got %b exp 0", c, force_brk); end
    end
    last_cyc = 0; nmi = 0; i_flag = 0;
    tick(SS + 1);
  endtask

  task automatic test_ready_stall;
    irq = 1; i_flag = 0;
    exp_vec.push_back(8'hFE);
    tick(SS);
    ready = 0; last_cyc = 1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL stall_hold cyc %0d got %b exp 0", c, force_brk); end
    end
    ready = 1; last_cyc = 0;
    tick(1);
    checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL stall_resume got %b exp 0", force_brk); end
    last_cyc = 1; tick(1); last_cyc = 0; #1;
    checks++; if (force_brk !== 1'b1) begin errors++; $display("FAIL stall_take got %b exp 1", force_brk); end
    ready = 0; vec_fetch = 1; #1;
    checks++; if (set_i !== 1'b0) begin errors++; $display("FAIL stall_set_i got %b exp 0", set_i); end
    tick(1);
    checks++; if (force_brk !== 1'b1) begin errors++; $display("FAIL stall_int got %b exp 1", force_brk); end
    ready = 1; #1;
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp || set_i !== 1'b1) begin
      errors++; $display("FAIL stall_vec got %h set_i %b exp %h 1", vector_lo, set_i, exp);
    end
    i_flag = 1;
    tick(1); vec_fetch = 0; irq = 0;
    tick(1);
    checks++; if (force_brk !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", force_brk); end
    i_flag = 0;
    tick(SS + 1);
  endtask

  task automatic test_reset_in_int;
    irq = 1; i_flag = 0;
    tick(SS);
    last_cyc = 1; tick(1); last_cyc = 0; #1;
    checks++; if (force_brk !== 1'b1) begin errors++; $display("FAIL rint_take got %b exp 1", force_brk); end
    nmi = 1;
    tick(SS + 1);
    checks++; if (nmi_pending !== 1'b1) begin errors++; $display("FAIL rint_nmi got %b exp 1", nmi_pending); end
    reset = 1;
    tick(1);
    checks++; if (vector_lo !== 8'hFC || wr_inhibit !== 1'b1 || nmi_pending !== 1'b0) begin
      errors++; $display("FAIL rint_reset got vec %h wr %b pend %b exp fc 1 0", vector_lo, wr_inhibit, nmi_pending);
    end
    reset = 0; irq = 0; nmi = 0;
    exp_vec.push_back(8'hFC);
    tick(2);
    vec_fetch = 1; #1;
    exp = exp_vec.pop_front();
    checks++; if (vector_lo !== exp) begin errors++; $display("FAIL rint_vec got %h exp %h", vector_lo, exp); end
    tick(1); vec_fetch = 0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_irq_masked;
    test_irq_take;
    test_nmi;
    test_hijack;
    test_ready_stall;
    test_reset_in_int;
    checks++; if (exp_vec.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_vec.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu6502_int_ctl.md
Name: cpu6502_int_ctl

Overview:
Interrupt/reset sequencer for the cpu6502 core; replaces the fixed vector_lo kludge and the hard-wired B-bit kludge.
Synchronises and edge-detects nmi, level-qualifies irq against the I flag, and samples requests at the instruction boundary.
Forces a BRK (opcode 00) into the core, holds PC, and supplies the vector low byte and the pushed B bit.
Runs the power-on/reset sequence with writes suppressed. Sits beside the microcode ROM and is driven by core timing strobes.

Parameters:
SYNC_STAGES, 2, synchroniser flops on the nmi and irq pins (0 means the pin is used directly).
VEC_NMI, 8'hFA, NMI vector low byte.
VEC_RST, 8'hFC, reset vector low byte.
VEC_IRQ, 8'hFE, IRQ/BRK vector low byte.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
nmi  in  1  NMI request pin, active-high, edge-triggered on rising edge
irq  in  1  IRQ request pin, active-high, level
ready  in  1  core ready; 0 stalls all sampling and state advance
last_cyc  in  1  core is in its final cycle (t_next==1); this is the sample point
i_flag  in  1  reg_p[I]
vec_fetch  in  1  microcode is selecting ADL_VECLO this cycle
force_brk  out  1  substitute 8'h00 for data_i as the opcode this cycle
pc_hold  out  1  suppress pc_inc
wr_inhibit  out  1  gate write to 0 (reset sequence)
b_flag  out  1  B bit value for the pushed P
vector_lo  out  8  vector low byte; the core uses vector_lo|1 for the high byte
set_i  out  1  set the I flag this cycle
nmi_pending  out  1  NMI latch state
irq_pending  out  1  irq_s & ~i_flag

Behaviour:
- nmi_s and irq_s are the pins delayed by SYNC_STAGES flops. nmi_prev <= nmi_s every cycle, including during reset.
- nmi_latch is set on (nmi_s & ~nmi_prev) and cleared on a vec_fetch edge when VEC_NMI was selected. Set wins over clear in the same cycle.
- States:
  - RST: entered while reset=1.
  - IDLE.
  - INT: forced BRK in progress.
  - VHI: the one vector-high cycle.
- RST:
  - Outputs: force_brk=1, pc_hold=1, wr_inhibit=1, b_flag=0, vector_lo=VEC_RST.
  - Leaves on vec_fetch&ready&~reset, going to VHI. The reset path does not clear nmi_latch.
- IDLE:
  - Outputs: force_brk=0, pc_hold=0, wr_inhibit=0, b_flag=1.
  - vector_lo is live: VEC_NMI if nmi_latch, else VEC_IRQ. This serves software BRK, and an NMI may hijack it.
  - On last_cyc&ready, if (nmi_latch | irq_pending), go to INT.
  - Decisions use registered values only: an NMI edge in the same cycle as last_cyc is taken at the next boundary.
- INT:
  - Outputs: force_brk=1, pc_hold=1, b_flag=0.
  - vector_lo is live: VEC_NMI if nmi_latch, else VEC_IRQ. This is the hijack window, up to and including the vec_fetch cycle.
  - On vec_fetch&ready, go to VHI.
- Vector hold: on any vec_fetch&ready edge, the live vector is captured into vec_hold.
- VHI:
  - vector_lo=vec_hold.
  - wr_inhibit/b_flag are those of the prior state, registered.
  - Next: IDLE if ready, else hold.
- set_i = vec_fetch & ready, in any state.
- ready=0: state, vec_hold and the sample point are frozen. Synchronisers and nmi_latch keep running.
- Deasserting irq after the take decision does not abort the sequence; BRK completes via VEC_IRQ.
- NMI held high produces exactly one take. A new take requires low then high.
- Reset mid-INT/VHI: the next state is RST and nmi_latch=0; the sequence restarts with VEC_RST.
- Reset values: state=RST, nmi_latch=0, vec_hold=VEC_RST, synchroniser flops=0.
  - Outputs during reset: force_brk=1, pc_hold=1, wr_inhibit=1, b_flag=0, vector_lo=8'hFC, set_i=0 unless vec_fetch, nmi_pending=0.

Decomposition:
- Add to 6502_inc.vh: ICTL_RST/IDLE/INT/VHI state encodings (2 bits), the VEC_* defaults, and the PF_B bit index.
- One sub-module, cpu6502_sync (an N-stage synchroniser, instanced twice).
- Edge detect and the FSM stay in the top.

Test Plan:
- Release reset, pulse vec_fetch 6 cycles later:
  - vector_lo=FC and wr_inhibit=1 throughout.
  - set_i=1 on the vec_fetch cycle.
  - Next cycle vector_lo=FC, state VHI; then IDLE with wr_inhibit=0.
- irq=1, i_flag=1 for 50 cycles with last_cyc pulses -> never INT, irq_pending=0.
- Drop i_flag -> after SYNC_STAGES cycles, the next last_cyc gives force_brk=1, b_flag=0, pc_hold=1; vec_fetch gives vector_lo=FE.
- nmi 0->1 held high -> nmi_pending=1 after SYNC_STAGES+1 cycles; take with vector FA, latch cleared at vec_fetch; no second take while nmi stays 1.
- IRQ taken, NMI edge 2 cycles before vec_fetch -> vector_lo=FA at vec_fetch, nmi_pending clears, no later NMI take (hijack).
- ready=0 across last_cyc with an irq pending -> no transition; ready=1 resumes, and the take occurs at the next qualified last_cyc.
- reset asserted in INT -> next cycle vector_lo=FC, wr_inhibit=1, nmi_pending=0.
